// File: rtl/seq_div_16b.sv
// seq_div_16b: multi-cycle 16-bit restoring divider, signed or unsigned.
// One shift-subtract step per cycle over 16 RUN cycles. Division by zero and
// signed 0x8000 / -1 bypass the iteration and saturate like the companion adder.
module seq_div_16b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        ovfl
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] rem_q;     // partial remainder R (always < divisor magnitude)
    logic [15:0] quo_q;     // working quotient Q, starts as dividend magnitude
    logic [15:0] dmag_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dz_pend_q; // flags staged for the FIX edge
    logic        ov_pend_q;

    logic [15:0] a_mag;
    logic [15:0] b_mag;
    logic [16:0] shifted;
    logic        sub_ok;
    logic [15:0] sub_res;
    logic [15:0] fix_quo;
    logic [15:0] fix_rem;

    // Operand magnitudes, one restoring step, and sign fix-up of the results
    always_comb begin
        a_mag   = (signed_op && dividend[15]) ? (~dividend + 16'd1) : dividend;
        b_mag   = (signed_op && divisor[15])  ? (~divisor + 16'd1)  : divisor;
        shifted = {rem_q, quo_q[15]};
        sub_ok  = (shifted >= {1'b0, dmag_q});
        // Low 16 bits of the 17-bit difference are exact whenever sub_ok holds
        sub_res = shifted[15:0] - dmag_q;
        fix_quo = q_neg_q ? (~quo_q + 16'd1) : quo_q;
        fix_rem = r_neg_q ? (~rem_q + 16'd1) : rem_q;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            rem_q       <= 16'h0000;
            quo_q       <= 16'h0000;
            dmag_q      <= 16'h0000;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_pend_q   <= 1'b0;
            ov_pend_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 16'h0000;
            remainder   <= 16'h0000;
            div_by_zero <= 1'b0;
            ovfl        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        busy      <= 1'b1;
                        dmag_q    <= b_mag;
                        dz_pend_q <= 1'b0;
                        ov_pend_q <= 1'b0;
                        if (divisor == 16'h0000) begin
                            // Final values staged in Q/R; FIX passes them through unsigned
                            dz_pend_q <= 1'b1;
                            q_neg_q   <= 1'b0;
                            r_neg_q   <= 1'b0;
                            quo_q     <= !signed_op ? 16'hFFFF :
                                         (dividend[15] ? 16'h8000 : 16'h7FFF);
                            rem_q     <= dividend;
                            state_q   <= StFix;
                        end else if (signed_op && dividend == 16'h8000 &&
                                     divisor == 16'hFFFF) begin
                            ov_pend_q <= 1'b1;
                            q_neg_q   <= 1'b0;
                            r_neg_q   <= 1'b0;
                            quo_q     <= 16'h7FFF;
                            rem_q     <= 16'h0000;
                            state_q   <= StFix;
                        end else begin
                            q_neg_q   <= signed_op & (dividend[15] ^ divisor[15]);
                            r_neg_q   <= signed_op & dividend[15];
                            quo_q     <= a_mag;
                            rem_q     <= 16'h0000;
                            cnt_q     <= 4'd15;
                            state_q   <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem_q <= sub_ok ? sub_res : shifted[15:0];
                    quo_q <= {quo_q[14:0], sub_ok};
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    quotient    <= fix_quo;
                    remainder   <= fix_rem;
                    div_by_zero <= dz_pend_q;
                    ovfl        <= ov_pend_q;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_16b.sv
// tb_seq_div_16b: directed and random checks of seq_div_16b against an
// arithmetic reference model (native integer / and % plus the saturation rules).
module tb_seq_div_16b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        ovfl;

    int n_assert;
    int n_fail;

    seq_div_16b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovfl        (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division with the saturation rules for the two special cases
    task automatic model(input logic sop, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov);
        int sa;
        int sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 16'h0000) begin
            dz = 1'b1;
            r  = a;
            if (!sop)      q = 16'hFFFF;
            else if (a[15]) q = 16'h8000;
            else            q = 16'h7FFF;
        end else if (sop && a == 16'h8000 && b == 16'hFFFF) begin
            ov = 1'b1;
            q  = 16'h7FFF;
            r  = 16'h0000;
        end else if (sop) begin
            sa = $signed({{16{a[15]}}, a});
            sb = $signed({{16{b[15]}}, b});
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
        end else begin
            q = 16'(int'(a) / int'(b));
            r = 16'(int'(a) % int'(b));
        end
    endtask

    // Issue one operation and check latency, results, flags and the single done pulse
    task automatic do_op(input logic sop, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        logic        eov;
        int          lat;
        int          cyc;
        model(sop, a, b, eq, er, edz, eov);
        lat = (edz || eov) ? 2 : 18;
        @(negedge clk);
        start     = 1'b1;
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start     = 1'b0;
        signed_op = 1'($urandom);
        dividend  = 16'($urandom);
        divisor   = 16'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(edz));
        check("ovfl", 32'(ovfl), 32'(eov));
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int          dcount;
        int          dcyc;
        logic [15:0] gq;
        logic [15:0] gr;
        logic        rsop;
        logic [15:0] ra;
        logic [15:0] rb;

        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = 16'h0000;
        divisor   = 16'h0000;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_by_zero, ovfl}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op(1'b0, 16'd100, 16'd7);
        do_op(1'b1, 16'hFFF9, 16'h0002);
        do_op(1'b0, 16'hFFFF, 16'h0001);
        do_op(1'b1, 16'h8000, 16'h0000);
        do_op(1'b0, 16'h0005, 16'h0000);
        do_op(1'b1, 16'h8000, 16'hFFFF);
        do_op(1'b1, 16'h7FFF, 16'hFFFF);
        do_op(1'b1, 16'h8000, 16'h0001);
        do_op(1'b1, 16'h0007, 16'hFFFE);

        // Second start during a busy operation must be ignored
        @(negedge clk);
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 16'd100;
        divisor   = 16'd7;
        @(negedge clk);
        start  = 1'b0;
        dcount = 0;
        dcyc   = 0;
        gq     = 16'h0000;
        gr     = 16'h0000;
        for (int c = 1; c <= 30; c++) begin
            if (done === 1'b1) begin
                dcount++;
                if (dcount == 1) begin
                    dcyc = c;
                    gq   = quotient;
                    gr   = remainder;
                end
            end
            if (c == 5) begin
                start     = 1'b1;
                signed_op = 1'b1;
                dividend  = 16'h1234;
                divisor   = 16'h0003;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("ignored_start_done_count", 32'(dcount), 32'd1);
        check("ignored_start_latency", 32'(dcyc), 32'd18);
        check("ignored_start_quotient", 32'(gq), 32'h000E);
        check("ignored_start_remainder", 32'(gr), 32'h0002);

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            rsop = 1'($urandom);
            ra   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = 16'($urandom_range(1, 15));
                1:       rb = 16'h0000 - 16'($urandom_range(1, 15));
                2:       rb = 16'h0000;
                3:       rb = 16'hFFFF;
                default: rb = 16'($urandom);
            endcase
            do_op(rsop, ra, rb);
        end

        // Asynchronous reset in the middle of RUN
        do_op(1'b0, 16'd100, 16'd7);
        @(negedge clk);
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 16'd100;
        divisor   = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_quotient", 32'(quotient), 32'd0);
        check("mid_rst_remainder", 32'(remainder), 32'd0);
        repeat (12) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done), 32'd0);
        end
        do_op(1'b0, 16'd100, 16'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
